// File: rtl/picosoc_mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous-read word memory.
// Fixed priority (m0 first) by default; define MEMARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module picosoc_mem_arbiter #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic                  owner;
  logic                  sel;
  logic                  start;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_wdata;
  logic [3:0]            cap_wstrb;

  // Byte offset and bits above the memory window are deliberately dropped (addresses alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                              m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

  assign start = (state == IDLE) && (m0_valid || m1_valid);

`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    if (m0_valid && m1_valid) sel = ~last_grant;
    else                      sel = ~m0_valid;
  end

  // Resets to m1 so that m0 wins the very first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    last_grant <= 1'b1;
    else if (start) last_grant <= sel;
  end
`else
  always_comb begin
    sel = ~m0_valid;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner     <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else if (start) begin
      owner     <= sel;
      cap_addr  <= sel ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
      cap_wdata <= sel ? m1_wdata : m0_wdata;
      cap_wstrb <= sel ? m1_wstrb : m0_wstrb;
    end
  end

  // Outputs decode from state so an async reset clears them without waiting for an edge.
  always_comb begin
    mem_wen   = 4'b0;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    grant     = 2'b00;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = 32'b0;
    m1_rdata  = 32'b0;
    case (state)
      ACCESS: begin
        mem_wen   = cap_wstrb;
        mem_addr  = cap_addr;
        mem_wdata = cap_wdata;
        grant     = owner ? 2'b10 : 2'b01;
      end
      RESP: begin
        mem_addr = cap_addr;
        grant    = owner ? 2'b10 : 2'b01;
        m0_ready = ~owner;
        m1_ready = owner;
        if (owner) m1_rdata = mem_rdata;
        else       m0_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Directed self-checking bench for picosoc_mem_arbiter with a read-first behavioural memory.
module tb_picosoc_mem_arbiter;

  localparam int ADDR_WIDTH = 5;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  m0_valid, m1_valid;
  logic [31:0]           m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]            m0_wstrb, m1_wstrb;
  logic                  m0_ready, m1_ready;
  logic [31:0]           m0_rdata, m1_rdata;
  logic [3:0]            mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic [1:0]            grant;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  int n_compared   = 0;
  int n_mismatched = 0;

  picosoc_mem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  // Read-first single-port memory: rdata is the word before any same-edge write.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one transfer on master m and wait (bounded) for its ready pulse; returns in IDLE.
  task automatic applyStimulus(input bit m, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata,
                               output int lat);
    bit seen = 0;
    lat   = 0;
    rdata = 32'hx;
    if (m) begin m1_valid = 1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; end
    else   begin m0_valid = 1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; end
    for (int i = 1; i <= 8 && !seen; i++) begin
      tick();
      if (m ? m1_ready : m0_ready) begin
        seen  = 1;
        lat   = i;
        rdata = m ? m1_rdata : m0_rdata;
      end
    end
    m0_valid = 0;
    m1_valid = 0;
    n_compared++;
    assert (seen) else begin
      n_mismatched++;
      $error("[TB] FAIL ready_timeout: observed no ready expected ready within 8 cycles");
    end
    tick();
  endtask

  task automatic pulseReset();
    #2 resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  logic [31:0] rd;
  int          lat;
  logic [1:0]  exp_owner [4];

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'hA500_0000 | i;
    resetn   = 0;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    #12;
    checkOutput("rst_grant", {30'b0, grant}, 32'h0);
    checkOutput("rst_wen", {28'b0, mem_wen}, 32'h0);
    checkOutput("rst_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
    checkOutput("rst_addr", {27'b0, mem_addr}, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 resetn = 1;

    $display("[TB] test1: m0 full-word write");
    m0_valid = 1; m0_addr = 32'h08; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
    checkOutput("t1_idle_wen", {28'b0, mem_wen}, 32'h0);
    tick();
    m0_valid = 0;
    m0_wdata = 32'h1111_1111;
    checkOutput("t1_acc_wen", {28'b0, mem_wen}, 32'hF);
    checkOutput("t1_acc_addr", {27'b0, mem_addr}, 32'd2);
    checkOutput("t1_acc_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("t1_acc_grant", {30'b0, grant}, 32'h1);
    checkOutput("t1_acc_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
    tick();
    checkOutput("t1_resp_ready", {30'b0, m1_ready, m0_ready}, 32'h1);
    checkOutput("t1_resp_wen", {28'b0, mem_wen}, 32'h0);
    checkOutput("t1_resp_addr", {27'b0, mem_addr}, 32'd2);
    checkOutput("t1_resp_wdata", mem_wdata, 32'h0);
    checkOutput("t1_resp_rdata", m0_rdata, 32'hA500_0002);
    tick();
    checkOutput("t1_idle_grant", {30'b0, grant}, 32'h0);
    checkOutput("t1_idle_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
    checkOutput("t1_mem_word2", mem[2], 32'hDEADBEEF);

    $display("[TB] test2: m1 byte write then m0 read");
    applyStimulus(1'b1, 32'h08, 32'h0000AB00, 4'b0010, rd, lat);
    checkOutput("t2_m1_lat", lat, 32'd2);
    checkOutput("t2_m1_prewrite", rd, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0A, 32'h0, 4'h0, rd, lat);
    checkOutput("t2_m0_rdata", rd, 32'hDEADABEF);

    $display("[TB] test3: simultaneous requests");
    pulseReset();
    m0_valid = 1; m0_addr = 32'h08; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'h0C; m1_wstrb = 0;
    tick();
    checkOutput("t3_c1_grant", {30'b0, grant}, 32'h1);
    tick();
    checkOutput("t3_c2_ready", {30'b0, m1_ready, m0_ready}, 32'h1);
    checkOutput("t3_c2_m0_rdata", m0_rdata, 32'hDEADABEF);
    checkOutput("t3_c2_m1_rdata", m1_rdata, 32'h0);
    m0_valid = 0;
    tick();
    checkOutput("t3_c3_grant", {30'b0, grant}, 32'h0);
    tick();
    checkOutput("t3_c4_grant", {30'b0, grant}, 32'h2);
    tick();
    checkOutput("t3_c5_ready", {30'b0, m1_ready, m0_ready}, 32'h2);
    checkOutput("t3_c5_m1_rdata", m1_rdata, 32'hA500_0003);
    m1_valid = 0;
    tick();

    $display("[TB] test4: both held valid for four transfers");
`ifdef MEMARB_ROUND_ROBIN_EN
    exp_owner = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_owner = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    pulseReset();
    m0_valid = 1; m0_addr = 32'h08; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'h0C; m1_wstrb = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      checkOutput($sformatf("t4_owner%0d", k), {30'b0, grant}, {30'b0, exp_owner[k]});
      checkOutput($sformatf("t4_ready%0d", k), {30'b0, m1_ready, m0_ready},
                  {30'b0, exp_owner[k]});
      if (k == 3) begin m0_valid = 0; m1_valid = 0; end
      tick();
    end

    $display("[TB] test5: address aliasing");
    m0_valid = 1; m0_addr = 32'h80; m0_wstrb = 0;
    tick();
    m0_valid = 0;
    checkOutput("t5_acc_addr", {27'b0, mem_addr}, 32'h0);
    tick();
    checkOutput("t5_rdata", m0_rdata, 32'hA500_0000);
    tick();

    $display("[TB] test6: reset during ACCESS of a write");
    m0_valid = 1; m0_addr = 32'h0C; m0_wdata = 32'h12345678; m0_wstrb = 4'hF;
    tick();
    checkOutput("t6_acc_wen", {28'b0, mem_wen}, 32'hF);
    #2 resetn = 0;
    #1;
    checkOutput("t6_rst_wen", {28'b0, mem_wen}, 32'h0);
    checkOutput("t6_rst_grant", {30'b0, grant}, 32'h0);
    checkOutput("t6_rst_addr", {27'b0, mem_addr}, 32'h0);
    m0_valid = 0;
    tick();
    checkOutput("t6_no_ready_a", {30'b0, m1_ready, m0_ready}, 32'h0);
    #1 resetn = 1;
    tick();
    checkOutput("t6_no_ready_b", {30'b0, m1_ready, m0_ready}, 32'h0);
    checkOutput("t6_word3", mem[3], 32'hA500_0003);
    applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0, rd, lat);
    checkOutput("t6_readback", rd, 32'hA500_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
